// File: rtl/verificador_pkg.sv
// Shared types and golden truth table for the gate-bank checker.
package verificador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_FINISH
  } state_t;

  localparam int NUM_GATES = 7;

  localparam int IDX_AND  = 6;
  localparam int IDX_NAND = 5;
  localparam int IDX_OR   = 4;
  localparam int IDX_NOR  = 3;
  localparam int IDX_NOT  = 2;
  localparam int IDX_XOR  = 1;
  localparam int IDX_XNOR = 0;

  function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
    logic [NUM_GATES-1:0] g;
    g           = '0;
    g[IDX_AND]  = a & b;
    g[IDX_NAND] = ~(a & b);
    g[IDX_OR]   = a | b;
    g[IDX_NOR]  = ~(a | b);
    g[IDX_NOT]  = ~a;
    g[IDX_XOR]  = a ^ b;
    g[IDX_XNOR] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/verificador_compuertas_contador_saturado.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module contador_saturado #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/verificador_compuertas.sv
// Sweeps all A/B combinations into a 2-input gate bank and checks the
// seven sampled results against the golden truth table.
module verificador_compuertas
  import verificador_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 A,
  output logic                 B,
  input  logic [NUM_GATES-1:0] gates_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [3:0]           fail_vec,
  output logic [NUM_GATES-1:0] fail_mask
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

  state_t               r_state;
  logic [1:0]           r_combo;
  logic [7:0]           r_pass_cnt;
  logic [3:0]           r_settle_cnt;
  logic                 r_a;
  logic                 r_b;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [3:0]           r_fail_vec;
  logic [NUM_GATES-1:0] r_fail_mask;

  logic [NUM_GATES-1:0] w_diff;
  logic                 w_mismatch;
  logic                 w_clr;
  logic                 w_inc;
  logic [1:0]           w_next_combo;
  logic [ERR_W-1:0]     w_err_count;

  assign w_diff       = gates_in ^ expected_gates(r_a, r_b);
  assign w_mismatch   = |w_diff;
  assign w_clr        = (r_state == ST_IDLE) && start;
  assign w_inc        = (r_state == ST_CHECK) && w_mismatch;
  assign w_next_combo = r_combo + 2'd1;

  contador_saturado #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .inc   (w_inc),
    .count (w_err_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_combo      <= 2'd0;
      r_pass_cnt   <= 8'd0;
      r_settle_cnt <= 4'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_vec   <= 4'd0;
      r_fail_mask  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_fail_vec   <= 4'd0;
            r_fail_mask  <= '0;
            r_pass       <= 1'b0;
            r_combo      <= 2'd0;
            r_pass_cnt   <= 8'd0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_settle_cnt <= SETTLE_LOAD;
            r_busy       <= 1'b1;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == 4'd0) begin
            r_state <= ST_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_fail_vec[r_combo] <= 1'b1;
            r_fail_mask         <= r_fail_mask | w_diff;
          end
          if ((r_combo == 2'd3) && (r_pass_cnt == LAST_PASS)) begin
            r_state <= ST_FINISH;
          end else begin
            if (r_combo == 2'd3) begin
              r_pass_cnt <= r_pass_cnt + 8'd1;
            end
            r_combo      <= w_next_combo;
            r_a          <= w_next_combo[1];
            r_b          <= w_next_combo[0];
            r_settle_cnt <= SETTLE_LOAD;
            r_state      <= ST_SETTLE;
          end
        end
        ST_FINISH: begin
          // counter already reflects the final CHECK at this point
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= (w_err_count == '0);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = w_err_count;
  assign fail_vec  = r_fail_vec;
  assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_verificador_compuertas.sv
// Directed bench: three checker instances, each facing a gate-bank model with selectable faults.
module tb_verificador_compuertas;

  logic clk;
  logic rst;

  logic       start_def, start_p3, start_sat;
  int         mode_def, mode_p3, mode_sat;
  logic       a_def, b_def, a_p3, b_p3, a_sat, b_sat;
  logic [6:0] g_def, g_p3, g_sat;
  logic       busy_def, done_def, pass_def;
  logic       busy_p3, done_p3, pass_p3;
  logic       busy_sat, done_sat, pass_sat;
  logic [7:0] err_def, err_p3;
  logic [1:0] err_sat;
  logic [3:0] fv_def, fv_p3, fv_sat;
  logic [6:0] fm_def, fm_p3, fm_sat;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gate bank model: 0 correct, 1 AND stuck-at-0, 2 XOR inverted, 3 all outputs tied low
  function automatic logic [6:0] bank(input logic a, input logic b, input int mode);
    logic [6:0] g;
    g = {a & b, ~(a & b), a | b, ~(a | b), ~a, a ^ b, ~(a ^ b)};
    case (mode)
      1: g[6] = 1'b0;
      2: g[1] = ~g[1];
      3: g = 7'h00;
      default: ;
    endcase
    return g;
  endfunction

  assign g_def = bank(a_def, b_def, mode_def);
  assign g_p3  = bank(a_p3,  b_p3,  mode_p3);
  assign g_sat = bank(a_sat, b_sat, mode_sat);

  verificador_compuertas u_def (
    .clk(clk), .rst(rst), .start(start_def), .A(a_def), .B(b_def), .gates_in(g_def),
    .busy(busy_def), .done(done_def), .pass(pass_def), .err_count(err_def),
    .fail_vec(fv_def), .fail_mask(fm_def)
  );

  verificador_compuertas #(.PASSES(3)) u_p3 (
    .clk(clk), .rst(rst), .start(start_p3), .A(a_p3), .B(b_p3), .gates_in(g_p3),
    .busy(busy_p3), .done(done_p3), .pass(pass_p3), .err_count(err_p3),
    .fail_vec(fv_p3), .fail_mask(fm_p3)
  );

  verificador_compuertas #(.ERR_W(2), .PASSES(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_sat), .A(a_sat), .B(b_sat), .gates_in(g_sat),
    .busy(busy_sat), .done(done_sat), .pass(pass_sat), .err_count(err_sat),
    .fail_vec(fv_sat), .fail_mask(fm_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: start_def = v;
      1: start_p3  = v;
      default: start_sat = v;
    endcase
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0: return done_def;
      1: return done_p3;
      default: return done_sat;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0: return busy_def;
      1: return busy_p3;
      default: return busy_sat;
    endcase
  endfunction

  // lat = rising edges after the accepting edge until done is seen high
  task automatic run(input int sel, input bit repulse, output int lat, output logic busy1);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    busy1 = busy_of(sel);
    lat   = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (repulse) set_start(sel, (lat == 2) || (lat == 4));
      if (done_of(sel)) break;
    end
    set_start(sel, 1'b0);
  endtask

  int   lat;
  logic busy1;
  int   extra_done;

  initial begin
    rst       = 1'b1;
    start_def = 1'b0;
    start_p3  = 1'b0;
    start_sat = 1'b0;
    mode_def  = 0;
    mode_p3   = 2;
    mode_sat  = 3;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ab",   {a_def, b_def}, 2'b00);
    chk("reset_busy", busy_def, 1'b0);
    chk("reset_done", done_def, 1'b0);
    chk("reset_pass", pass_def, 1'b0);
    chk("reset_err",  err_def, 8'd0);
    chk("reset_fv",   fv_def, 4'b0000);
    chk("reset_fm",   fm_def, 7'h00);
    @(negedge clk);
    rst = 1'b0;

    // correct bank, defaults
    run(0, 1'b0, lat, busy1);
    chk("ok_busy_after_start", busy1, 1'b1);
    chk("ok_latency", lat, 13);
    chk("ok_pass", pass_def, 1'b1);
    chk("ok_err",  err_def, 8'd0);
    chk("ok_fv",   fv_def, 4'b0000);
    chk("ok_fm",   fm_def, 7'h00);
    chk("ok_busy_at_done", busy_def, 1'b0);
    chk("ok_ab_final", {a_def, b_def}, 2'b11);
    @(posedge clk);
    #1;
    chk("ok_done_one_cycle", done_def, 1'b0);

    // AND stuck at 0
    mode_def = 1;
    run(0, 1'b0, lat, busy1);
    chk("and0_latency", lat, 13);
    chk("and0_err",  err_def, 8'd1);
    chk("and0_fv",   fv_def, 4'b1000);
    chk("and0_fm",   fm_def, 7'b1000000);
    chk("and0_pass", pass_def, 1'b0);

    // XOR inverted, PASSES=3
    run(1, 1'b0, lat, busy1);
    chk("xor_latency", lat, 37);
    chk("xor_err",  err_p3, 8'd12);
    chk("xor_fv",   fv_p3, 4'b1111);
    chk("xor_fm",   fm_p3, 7'b0000010);
    chk("xor_pass", pass_p3, 1'b0);

    // all gates tied low, ERR_W=2, PASSES=2: 8 mismatches saturate at 3
    run(2, 1'b0, lat, busy1);
    chk("sat_latency", lat, 25);
    chk("sat_err",  err_sat, 2'd3);
    chk("sat_fv",   fv_sat, 4'b1111);
    chk("sat_fm",   fm_sat, 7'b1111111);
    chk("sat_pass", pass_sat, 1'b0);

    // start re-pulsed mid-run is ignored
    mode_def = 0;
    run(0, 1'b1, lat, busy1);
    chk("repulse_latency", lat, 13);
    chk("repulse_pass", pass_def, 1'b1);
    chk("repulse_err",  err_def, 8'd0);
    chk("repulse_fv",   fv_def, 4'b0000);
    chk("repulse_fm",   fm_def, 7'h00);
    extra_done = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (done_def) extra_done++;
    end
    chk("repulse_single_done", extra_done, 0);
    chk("repulse_idle_busy", busy_def, 1'b0);

    // reset during SETTLE of combo 2
    @(negedge clk);
    start_def = 1'b1;
    @(posedge clk);
    #1;
    start_def = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("midrst_pre_ab",   {a_def, b_def}, 2'b10);
    chk("midrst_pre_busy", busy_def, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_ab",   {a_def, b_def}, 2'b00);
    chk("midrst_busy", busy_def, 1'b0);
    chk("midrst_pass", pass_def, 1'b0);
    chk("midrst_err",  err_def, 8'd0);
    chk("midrst_fv",   fv_def, 4'b0000);
    chk("midrst_fm",   fm_def, 7'h00);
    extra_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done_def) extra_done++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (done_def) extra_done++;
    end
    chk("midrst_no_done", extra_done, 0);

    run(0, 1'b0, lat, busy1);
    chk("post_rst_latency", lat, 13);
    chk("post_rst_pass", pass_def, 1'b1);
    chk("post_rst_err",  err_def, 8'd0);
    chk("post_rst_fv",   fv_def, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
